// File: rtl/alu_exec_if.sv
// Execute-stage handshake bundle: operation in (valid/ready), registered result out (valid/ready).
// master = upstream/writeback side driving ops and out_ready, slave = the alu_exec stage.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] Y;
  logic            zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, Y, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, Y, zero
  );
endinterface

// File: rtl/alu_exec.sv
// RV32I execute stage: 1-cycle ALU ops, shifts 1 bit/cycle (shamt extra cycles) unless ALU_FAST_SHIFT_EN.
// Result held in DONE until out_ready; in_ready only in IDLE, so no path from out_ready to in_ready.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_exec_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
`ifndef ALU_FAST_SHIFT_EN
  localparam logic [1:0] S_SHIFT = 2'd1;
`endif
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] y_q, y_d;
  logic            zero_q, zero_d;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] shift_res;
  logic [4:0]      shamt;
  logic            is_shift;

  assign shamt    = bus.b[4:0];
  assign is_shift = (bus.op == 4'b0001) || (bus.op == 4'b0101) || (bus.op == 4'b1101);

`ifdef ALU_FAST_SHIFT_EN
  always_comb begin
    case (bus.op)
      4'b0001: shift_res = bus.a << shamt;
      4'b0101: shift_res = bus.a >> shamt;
      default: shift_res = XLEN'($signed(bus.a) >>> shamt);
    endcase
  end
`else
  logic [XLEN-1:0] sreg_q, sreg_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [1:0]      kind_q, kind_d;
  logic [XLEN-1:0] step;

  // Only reached in IDLE for shamt == 0, where the shift is the identity.
  assign shift_res = bus.a;

  // kind encodes {op[3], op[2]}: 00 SLL, 01 SRL, 11 SRA
  always_comb begin
    case (kind_q)
      2'b00:   step = {sreg_q[XLEN-2:0], 1'b0};
      2'b01:   step = {1'b0, sreg_q[XLEN-1:1]};
      default: step = {sreg_q[XLEN-1], sreg_q[XLEN-1:1]};
    endcase
  end
`endif

  always_comb begin
    case (bus.op)
      4'b0000: alu_res = bus.a + bus.b;
      4'b1000: alu_res = bus.a - bus.b;
      4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      4'b0100: alu_res = bus.a ^ bus.b;
      4'b0110: alu_res = bus.a | bus.b;
      4'b0111: alu_res = bus.a & bus.b;
      4'b0001,
      4'b0101,
      4'b1101: alu_res = shift_res;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    zero_d  = zero_q;
`ifndef ALU_FAST_SHIFT_EN
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
          if (is_shift && (shamt != 5'd0)) begin
            sreg_d  = bus.a;
            cnt_d   = shamt;
            kind_d  = bus.op[3:2];
            state_d = S_SHIFT;
          end else
`endif
          begin
            y_d     = alu_res;
            zero_d  = (alu_res == '0);
            state_d = S_DONE;
          end
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        sreg_d = step;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          y_d     = step;
          zero_d  = (step == '0);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      zero_q  <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
      sreg_q  <= '0;
      cnt_q   <= '0;
      kind_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
`ifndef ALU_FAST_SHIFT_EN
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.Y         = y_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vector table, backpressure and reset-mid-shift sequences, random ops vs model.
module tb_alu_exec;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  alu_exec_if #(.XLEN(32)) bus ();

  alu_exec #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference result straight from the opcode table.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sh;
    logic [31:0] ones;
    sh   = int'(b[4:0]);
    ones = 32'hFFFF_FFFF;
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
      4'b0010: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  // Cycles spent with out_valid low after the accept edge: shamt for iterative shifts, else none.
  function automatic int exp_wait(input logic [3:0] op, input logic [31:0] b);
    if (!FAST && (op == 4'b0001 || op == 4'b0101 || op == 4'b1101)) return int'(b[4:0]);
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for the result, optionally stall, then consume it.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_y, input int hold);
    int waits;
    bit saw_rdy;
    check({name, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    bus.op       = 4'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    waits   = 0;
    saw_rdy = 1'b0;
    while (!bus.out_valid && waits < 200) begin
      saw_rdy |= bus.in_ready;
      tick();
      waits++;
    end
    check({name, "/latency"}, 32'(waits), 32'(exp_wait(op, b)));
    if (waits > 0) check({name, "/in_ready_busy"}, 32'(saw_rdy), 32'd0);
    check({name, "/Y"}, bus.Y, exp_y);
    check({name, "/zero"}, 32'(bus.zero), 32'(exp_y == 32'h0));
    for (int i = 0; i < hold; i++) tick();
    if (hold > 0) begin
      check({name, "/held_Y"}, bus.Y, exp_y);
      check({name, "/held_vld_rdy"}, 32'({bus.out_valid, bus.in_ready}), 32'b10);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, "/release"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
  endtask

  vec_t tbl[$];

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] y_hold;
    tests = 0;
    fails = 0;

    tbl.push_back('{"xor",      4'b0100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F});
    tbl.push_back('{"xor_zero", 4'b0100, 32'h00000001, 32'h00000001, 32'h00000000});
    tbl.push_back('{"sub",      4'b1000, 32'd5,        32'd7,        32'hFFFFFFFE});
    tbl.push_back('{"add_wrap", 4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    tbl.push_back('{"slt",      4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    tbl.push_back('{"sltu",     4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    tbl.push_back('{"sra4",     4'b1101, 32'h80000000, 32'h00000024, 32'hF8000000});
    tbl.push_back('{"sll0",     4'b0001, 32'h12345678, 32'hFFFFFFE0, 32'h12345678});
    tbl.push_back('{"srl31",    4'b0101, 32'hFFFFFFFF, 32'h0000001F, 32'h00000001});
    tbl.push_back('{"sll1",     4'b0001, 32'h80000001, 32'h00000001, 32'h00000002});
    tbl.push_back('{"illegal",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
    tbl.push_back('{"and",      4'b0111, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030});
    tbl.push_back('{"or",       4'b0110, 32'hF0000000, 32'h0000000F, 32'hF000000F});

    bus.in_valid  = 1'b0;
    bus.op        = 4'h0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/out_valid", 32'(bus.out_valid), 32'd0);
    check("reset/in_ready", 32'(bus.in_ready), 32'd1);
    check("reset/Y", bus.Y, 32'h0);
    check("reset/zero", 32'(bus.zero), 32'd1);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) do_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y, 0);

    // Backpressure: 3 stalled cycles, then consume with a new accept in the very next cycle.
    do_op("bp", 4'b0000, 32'd40, 32'd2, 32'd42, 3);
    bus.in_valid = 1'b1;
    bus.op       = 4'b0000;
    bus.a        = 32'd10;
    bus.b        = 32'd20;
    tick();
    bus.in_valid = 1'b0;
    check("bp_next/out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_next/Y", bus.Y, 32'd30);
    y_hold = bus.Y;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_next/released", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    check("bp_next/Y_kept", bus.Y, y_hold);

    // Reset in the middle of a long shift; inputs toggling during reset must be ignored.
    bus.in_valid = 1'b1;
    bus.op       = 4'b0001;
    bus.a        = 32'h1;
    bus.b        = 32'd20;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = 4'b0110;
    bus.a        = 32'hDEADBEEF;
    #1;
    check("rst_mid/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid/Y", bus.Y, 32'h0);
    check("rst_mid/zero", 32'(bus.zero), 32'd1);
    check("rst_mid/in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) tick();
    bus.in_valid = 1'b0;
    #4;
    rst_n = 1'b1;
    repeat (25) tick();
    check("rst_after/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_after/Y", bus.Y, 32'h0);
    do_op("rst_after_add", 4'b0000, 32'd2, 32'd3, 32'd5, 0);

    for (int n = 0; n < 300; n++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = $urandom;
      if (n % 4 == 0) r_a = 32'($urandom_range(0, 3)) << 30;
      if (n % 5 == 0) r_b = r_a;
      do_op($sformatf("rand%0d_op%0h", n, r_op), r_op, r_a, r_b, model(r_op, r_a, r_b),
            int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
